// File: rtl/demux_scheduler_if.sv
// Handshake bundle between the scheduler, its input FIFO and the class demux.
//   fifo_empty/fifo_head : FWFT input FIFO status and head word
//   fifo_pop             : pop the input FIFO (combinational)
//   data_out/cls/valid   : word, class and push enable toward the demux
//   credit_ret           : bit i = output FIFO i popped this cycle
// The demux class field is named cls because "class" is a reserved word.
interface demux_scheduler_if #(
  parameter int unsigned DATA_W = 12
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_pop;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        cls;
  logic              valid;
  logic [3:0]        credit_ret;

  // Environment side: drives the input FIFO and the credit returns.
  modport master (
    output fifo_empty, fifo_head, credit_ret,
    input  fifo_pop, data_out, cls, valid
  );

  // Scheduler side.
  modport slave (
    input  fifo_empty, fifo_head, credit_ret,
    output fifo_pop, data_out, cls, valid
  );
endinterface

// File: rtl/demux_scheduler.sv
// Credit-based scheduler in front of the 4-way class demux.
// Pops words from an FWFT FIFO and forwards each one with its class, but only
// when the destination output FIFO has a credit; credits come back on pop.
// Ports:
//   clk, reset_L     : clock, asynchronous active-low reset
//   init             : request (re)initialisation
//   cfg_credits      : credits per class, loaded while in INIT
//   bus (slave)      : FIFO / demux / credit-return handshake
//   credits          : credit counters, class i in [i*CW +: CW]
//   state            : RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4
//   idle, error      : state decodes
module demux_scheduler #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CW     = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [CW-1:0]        cfg_credits,
  demux_scheduler_if.slave     bus,
  output logic [4*CW-1:0]      credits,
  output logic [2:0]           state,
  output logic                 idle,
  output logic                 error
);

  localparam int unsigned NCLS = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   credit_q [NCLS];
  logic [CW-1:0]   credit_d [NCLS];
  logic [CW-1:0]   cred_max_q;
  logic [CW-1:0]   cfg_clamped;
  logic [1:0]      head_cls;
  logic            pop_c;
  logic [NCLS-1:0] send_vec;
  logic            ovf_c;
  logic            all_max_c;

  assign head_cls = bus.fifo_head[DATA_W-1 -: 2];

  // Zero or out-of-range configurations fall back to the full FIFO depth.
  assign cfg_clamped = (cfg_credits == '0 || cfg_credits > CW'(DEPTH))
                       ? CW'(DEPTH) : cfg_credits;

  // A send needs a credit held at the start of the cycle; a same-cycle
  // return only becomes usable next cycle.
  assign pop_c = (state_q == ST_ACTIVE) & ~init & ~bus.fifo_empty &
                 (credit_q[head_cls] != '0);
  assign bus.fifo_pop = pop_c;

  // One-hot class of the word being sent this cycle.
  always_comb begin
    send_vec = '0;
    if (pop_c) send_vec[head_cls] = 1'b1;
  end

  // Next credit values plus overflow and all-credits-home detection.
  always_comb begin
    ovf_c     = 1'b0;
    all_max_c = 1'b1;
    for (int i = 0; i < int'(NCLS); i++) begin
      credit_d[i] = credit_q[i];
      case (state_q)
        ST_INIT: credit_d[i] = cfg_clamped;
        ST_IDLE, ST_ACTIVE: begin
          // A return into a full counter is a protocol error; the count holds.
          if (bus.credit_ret[i] && !send_vec[i] && credit_q[i] == cred_max_q)
            ovf_c = 1'b1;
          else
            credit_d[i] = credit_q[i] - CW'(send_vec[i]) + CW'(bus.credit_ret[i]);
        end
        default: credit_d[i] = credit_q[i];
      endcase
      if (credit_d[i] != cred_max_q) all_max_c = 1'b0;
    end
  end

  // Next-state logic; init wins over everything, overflow over idle/active moves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  state_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (init)                 state_d = ST_INIT;
        else if (ovf_c)           state_d = ST_ERROR;
        else if (!bus.fifo_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                             state_d = ST_INIT;
        else if (ovf_c)                       state_d = ST_ERROR;
        else if (bus.fifo_empty && all_max_c) state_d = ST_IDLE;
      end
      ST_ERROR: if (init) state_d = ST_INIT;
      default:  state_d = ST_RESET;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  // Credit counters, their configured maximum and the status decodes.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < int'(NCLS); i++) credit_q[i] <= '0;
      cred_max_q <= '0;
      idle       <= 1'b0;
      error      <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NCLS); i++) credit_q[i] <= credit_d[i];
      if (state_q == ST_INIT) cred_max_q <= cfg_clamped;
      idle  <= (state_d == ST_IDLE);
      error <= (state_d == ST_ERROR);
    end
  end

  // Output word register toward the demux; word/class hold between sends.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bus.data_out <= '0;
      bus.cls      <= '0;
      bus.valid    <= 1'b0;
    end else begin
      bus.valid <= pop_c;
      if (pop_c) begin
        bus.data_out <= bus.fifo_head;
        bus.cls      <= head_cls;
      end
    end
  end

  for (genvar g = 0; g < int'(NCLS); g++) begin : g_credits
    assign credits[g*CW +: CW] = credit_q[g];
  end

  assign state = 3'(state_q);

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler with an abstract reference model.
module tb_demux_scheduler;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = 3;

  logic              clk;
  logic              reset_L;
  logic              init;
  logic [CW-1:0]     cfg_credits;
  logic [4*CW-1:0]   credits;
  logic [2:0]        state;
  logic              idle;
  logic              error;

  demux_scheduler_if #(.DATA_W(DATA_W)) bus ();

  demux_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .init        (init),
    .cfg_credits (cfg_credits),
    .bus         (bus),
    .credits     (credits),
    .state       (state),
    .idle        (idle),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Input FIFO contents owned by the bench.
  logic [DATA_W-1:0] q[$];

  // Reference model: plain integers following the behavioural rules.
  int m_state;
  int m_cred[4];
  int m_max;
  int m_valid;
  int m_data;
  int m_cls;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0;
    for (int i = 0; i < 4; i++) m_cred[i] = 0;
    m_max = 0; m_valid = 0; m_data = 0; m_cls = 0;
  endtask

  function automatic int head_class();
    logic [DATA_W-1:0] h;
    h = q[0];
    return int'(h[DATA_W-1:DATA_W-2]);
  endfunction

  // A word leaves only in ACTIVE, without init, with a credit for its class.
  function automatic bit exp_pop();
    if (m_state != 3 || init || q.size() == 0) return 1'b0;
    return m_cred[head_class()] != 0;
  endfunction

  task automatic drive_fifo();
    bus.fifo_empty = (q.size() == 0);
    bus.fifo_head  = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    q.push_back(w);
    drive_fifo();
  endtask

  function automatic int dut_cred(input int i);
    return int'(credits[i*CW +: CW]);
  endfunction

  // Advance one clock: evaluate the model on the current inputs, then let the edge happen.
  task automatic step();
    bit p;
    int ns;
    int nc[4];
    int nmax;
    int hc;
    bit ovf;
    bit allmax;
    if (!reset_L) begin
      @(posedge clk);
      #1;
      return;
    end
    p = exp_pop();
    hc = (q.size() != 0) ? head_class() : 0;
    ns = m_state;
    nmax = m_max;
    for (int i = 0; i < 4; i++) nc[i] = m_cred[i];
    case (m_state)
      0: ns = 1;
      1: begin
        nmax = (cfg_credits == 0 || int'(cfg_credits) > int'(DEPTH)) ? int'(DEPTH) : int'(cfg_credits);
        for (int i = 0; i < 4; i++) nc[i] = nmax;
        ns = init ? 1 : 2;
      end
      2, 3: begin
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
          int s;
          int r;
          s = (p && hc == i) ? 1 : 0;
          r = bus.credit_ret[i] ? 1 : 0;
          if (r == 1 && s == 0 && m_cred[i] == m_max) ovf = 1'b1;
          else nc[i] = m_cred[i] - s + r;
        end
        allmax = 1'b1;
        for (int i = 0; i < 4; i++) if (nc[i] != m_max) allmax = 1'b0;
        if (init) ns = 1;
        else if (ovf) ns = 4;
        else if (m_state == 2) ns = (q.size() != 0) ? 3 : 2;
        else ns = (q.size() == 0 && allmax) ? 2 : 3;
      end
      default: ns = init ? 1 : 4;
    endcase
    @(posedge clk);
    m_state = ns;
    m_max = nmax;
    for (int i = 0; i < 4; i++) m_cred[i] = nc[i];
    m_valid = p ? 1 : 0;
    if (p) begin
      m_data = int'(q[0]);
      m_cls  = hc;
    end
    #1;
    if (p) void'(q.pop_front());
    drive_fifo();
  endtask

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("fifo_pop", int'(bus.fifo_pop), int'(exp_pop()));
      chk("valid",    int'(bus.valid),    m_valid);
      chk("data_out", int'(bus.data_out), m_data);
      chk("class",    int'(bus.cls),      m_cls);
      chk("state",    int'(state),        m_state);
      chk("idle",     int'(idle),         (m_state == 2) ? 1 : 0);
      chk("error",    int'(error),        (m_state == 4) ? 1 : 0);
      for (int i = 0; i < 4; i++) chk("credit", dut_cred(i), m_cred[i]);
    end
  end

  initial begin
    reset_L = 1'b0;
    init = 1'b1;
    cfg_credits = 3'd3;
    bus.credit_ret = 4'b0000;
    drive_fifo();
    m_reset();
    chk_en = 1'b1;

    // Reset then init with 3 credits per class.
    step(); step();
    chk("rst_state", int'(state), 0);
    chk("rst_valid", int'(bus.valid), 0);
    reset_L = 1'b1;
    step();
    chk("init_state", int'(state), 1);
    step();
    init = 1'b0;
    step();
    #1;
    chk("idle_state", int'(state), 2);
    chk("idle_flag", int'(idle), 1);
    for (int i = 0; i < 4; i++) chk("init_cred", dut_cred(i), 3);

    // Single send of a class-3 word.
    push(12'hC05);
    step();
    #1;
    chk("single_pop", int'(bus.fifo_pop), 1);
    step();
    #1;
    chk("single_valid", int'(bus.valid), 1);
    chk("single_data", int'(bus.data_out), 'hC05);
    chk("single_class", int'(bus.cls), 3);
    chk("single_cred3", dut_cred(3), 2);
    chk("model_cred3", m_cred[3], 2);
    bus.credit_ret = 4'b1000;
    step();
    bus.credit_ret = 4'b0000;
    #1;
    chk("drain_idle", int'(idle), 1);

    // Credit exhaustion on class 1, then one return lets exactly one word out.
    for (int i = 1; i <= 5; i++) push(12'(12'h400 + i));
    step();
    step(); step(); step();
    #1;
    chk("exh_pop", int'(bus.fifo_pop), 0);
    chk("exh_cred1", dut_cred(1), 0);
    step();
    bus.credit_ret = 4'b0010;
    #1;
    chk("ret_blocks", int'(bus.fifo_pop), 0);
    step();
    bus.credit_ret = 4'b0000;
    #1;
    chk("ret_pop", int'(bus.fifo_pop), 1);
    step();
    #1;
    chk("ret_data", int'(bus.data_out), 'h404);
    chk("ret_pop_after", int'(bus.fifo_pop), 0);

    // Drain the last class-1 word and bring all class-1 credits home.
    bus.credit_ret = 4'b0010;
    step();
    bus.credit_ret = 4'b0000;
    step();
    bus.credit_ret = 4'b0010;
    step(); step(); step();
    bus.credit_ret = 4'b0000;
    #1;
    chk("drain2_idle", int'(state), 2);

    // Simultaneous send and return on class 2.
    push(12'h801);
    push(12'h802);
    step();
    step();
    #1;
    chk("sim_cred2_pre", dut_cred(2), 2);
    bus.credit_ret = 4'b0100;
    step();
    bus.credit_ret = 4'b0000;
    #1;
    chk("sim_cred2", dut_cred(2), 2);
    chk("sim_data", int'(bus.data_out), 'h802);
    bus.credit_ret = 4'b0100;
    step();
    bus.credit_ret = 4'b0000;
    #1;
    chk("sim_idle", int'(idle), 1);

    // Overflow from IDLE: sticky error, no pops, returns ignored.
    push(12'h010);
    bus.credit_ret = 4'b0001;
    step();
    bus.credit_ret = 4'b0000;
    #1;
    chk("ovf_state", int'(state), 4);
    chk("ovf_error", int'(error), 1);
    chk("ovf_pop", int'(bus.fifo_pop), 0);
    bus.credit_ret = 4'b0011;
    step();
    bus.credit_ret = 4'b0000;
    step();
    #1;
    chk("err_cred0", dut_cred(0), 3);
    chk("err_cred1", dut_cred(1), 3);
    chk("err_state", int'(state), 4);

    // Re-init with out-of-range values, then a legal value.
    init = 1'b1;
    cfg_credits = 3'd6;
    step();
    #1;
    chk("reinit_state", int'(state), 1);
    step();
    #1;
    chk("clamp_hi", dut_cred(0), 4);
    cfg_credits = 3'd0;
    step();
    #1;
    chk("clamp_zero", dut_cred(2), 4);
    cfg_credits = 3'd2;
    init = 1'b0;
    step();
    #1;
    chk("reinit_idle", int'(state), 2);
    chk("reinit_cred", dut_cred(1), 2);
    step();
    #1;
    chk("resume_pop", int'(bus.fifo_pop), 1);
    step();
    #1;
    chk("resume_valid", int'(bus.valid), 1);

    // Asynchronous reset drops the in-flight valid immediately.
    #2;
    reset_L = 1'b0;
    m_reset();
    #1;
    chk("async_valid", int'(bus.valid), 0);
    chk("async_state", int'(state), 0);
    chk("async_cred", dut_cred(0), 0);
    step();
    reset_L = 1'b1;
    step();
    step();
    #1;
    chk("post_rst_idle", int'(state), 2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
